// File: rtl/fx_pkg.sv
// Shared Q4.16 fixed-point definitions for the neuron datapath (MAC and sigmoid).
package fx_pkg;

  localparam int DW   = 20;
  localparam int FRAC = 16;

  localparam logic [DW-1:0] FX_MAX = 20'h7FFFF;
  localparam logic [DW-1:0] FX_MIN = 20'h80000;
  localparam int            FX_ONE = 65536;

  typedef logic signed [DW-1:0] fx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } mac_state_t;

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up and saturate a wide Q.32-style accumulator down to a DW-bit fixed-point value.
module fx_round_sat #(
  parameter int ACC_W = 48,
  parameter int DW    = 20,
  parameter int FRAC  = 16
) (
  input  logic signed [ACC_W-1:0] val_i,
  output logic signed [DW-1:0]    z_o,
  output logic                    sat_o
);

  // One guard bit so adding the half-LSB can never wrap.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF  = RW'(1) << (FRAC - 1);
  localparam logic signed [RW-1:0] MAX_R = (RW'(1) << (DW - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MIN_R = -(RW'(1) << (DW - 1));

  function automatic logic signed [RW-1:0] round_half_up(input logic signed [ACC_W-1:0] v);
    logic signed [RW-1:0] t;
    t = {v[ACC_W-1], v};
    t = t + HALF;
    return t >>> FRAC;
  endfunction

  function automatic logic [DW:0] saturate(input logic signed [RW-1:0] r);
    if (r > MAX_R) begin
      return {1'b1, MAX_R[DW-1:0]};
    end else if (r < MIN_R) begin
      return {1'b1, MIN_R[DW-1:0]};
    end else begin
      return {1'b0, r[DW-1:0]};
    end
  endfunction

  logic signed [RW-1:0] r;
  logic [DW:0]          rs;

  assign r     = round_half_up(val_i);
  assign rs    = saturate(r);
  assign sat_o = rs[DW];
  assign z_o   = rs[DW-1:0];

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate producing a neuron's saturated Q4.16 pre-activation
// (bias + sum of x*w) under a valid/ready handshake; feeds the sigmoid stage.
module neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int DW       = 20,
  parameter int FRAC     = 16,
  parameter int ACC_W    = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] w_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] z_pre,
  output logic                 sat,
  output logic                 busy
);
  import fx_pkg::*;

  localparam int         PW       = 2 * DW;
  localparam logic [7:0] LAST_CNT = 8'(N_INPUTS - 1);

  mac_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [DW-1:0]    z_q, z_d;
  logic                    sat_q, sat_d;
  logic signed [PW-1:0]    prod_p0;
  logic                    vld_p0;
  logic                    beat;
  logic                    round_done;
  logic signed [DW-1:0]    rs_z;
  logic                    rs_sat;

  assign beat       = in_valid && in_ready;
  // ROUND waits until the product still in flight has been absorbed.
  assign round_done = (state_q == ROUND) && !vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (beat && (cnt_q == LAST_CNT)) state_d = ROUND;
      ROUND:   if (!vld_p0) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  // Stage p0: registered product
  always_ff @(posedge clk) begin
    if (beat) prod_p0 <= PW'(x_in) * PW'(w_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= beat;
  end

  // Stage p1: accumulate, then round/saturate into the held output
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if ((state_q == IDLE) && start) begin
      acc_d = $signed({{(ACC_W-DW){bias[DW-1]}}, bias}) <<< FRAC;
      cnt_d = 8'd0;
    end else begin
      if (vld_p0) acc_d = acc_q + $signed({{(ACC_W-PW){prod_p0[PW-1]}}, prod_p0});
      if (beat)   cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    z_d   = z_q;
    sat_d = sat_q;
    if (round_done) begin
      z_d   = rs_z;
      sat_d = rs_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      z_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
      sat_q <= sat_d;
    end
  end

  fx_round_sat #(
    .ACC_W (ACC_W),
    .DW    (DW),
    .FRAC  (FRAC)
  ) u_round_sat (
    .val_i (acc_q),
    .z_o   (rs_z),
    .sat_o (rs_sat)
  );

  assign z_pre = z_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed fixed-point cases plus randomized
// evaluations compared against an integer-arithmetic reference of bias + sum(x*w).
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] x_in = '0;
  logic [19:0] w_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] z_pre;
  logic        sat;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int xs[8];
  int ws[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_pre     (z_pre),
    .sat       (sat),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_fx(input int mag);
    return int'($urandom_range(0, 2 * mag)) - mag;
  endfunction

  task automatic clear_pairs;
    for (int i = 0; i < 8; i++) begin
      xs[i] = 0;
      ws[i] = 0;
    end
  endtask

  task automatic random_pairs;
    for (int i = 0; i < 8; i++) begin
      xs[i] = rnd_fx(196608);
      ws[i] = rnd_fx(196608);
    end
  endtask

  // Reference: exact integer sum in Q.32, round half up, clip to Q4.16.
  function automatic void model(input int b, output logic [19:0] z, output logic s);
    longint sum;
    longint r;
    sum = longint'(b) * 65536;
    for (int i = 0; i < 8; i++) sum += longint'(xs[i]) * longint'(ws[i]);
    r = (sum + 32768) >>> 16;
    if (r > 524287) begin
      z = 20'h7FFFF; s = 1'b1;
    end else if (r < -524288) begin
      z = 20'h80000; s = 1'b1;
    end else begin
      z = r[19:0];   s = 1'b0;
    end
  endfunction

  // Drives one evaluation up to out_valid; returns result and timing.
  task automatic run_eval(input int b, input bit gaps, input bit start_noise,
                          output logic [19:0] z, output logic s,
                          output int lat, output int len, output bit tmo);
    int  i, guard, last_cyc, start_cyc;
    bit  v, rdy;
    z = '0; s = 1'b0; lat = -1; len = -1; tmo = 1'b0; last_cyc = 0;
    start = 1'b1;
    bias  = 20'(b);
    tick;
    start_cyc = cyc;
    start = 1'b0;
    i = 0;
    guard = 0;
    while (i < 8 && guard < 400) begin
      v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      x_in     = 20'(xs[i]);
      w_in     = 20'(ws[i]);
      start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy      = in_ready;
      tick;
      guard++;
      if (v && rdy) begin
        i++;
        last_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
      guard++;
    end
    start = 1'b0;
    if (!out_valid) begin
      tmo = 1'b1;
    end else begin
      lat = cyc - last_cyc;
      len = cyc - start_cyc;
      z   = z_pre;
      s   = sat;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    start     = 1'b0;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    start = 1'b1;
    repeat (2) tick;
    start = 1'b0;
    n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (z_pre !== 20'h0)    begin n_fail++; $display("FAIL rst_z_pre got %h want 00000", z_pre); end
    n_cmp++; if (sat !== 1'b0)       begin n_fail++; $display("FAIL rst_sat got %b want 0", sat); end
    #2 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic_sum;
    logic [19:0] z; logic s; int lat, len; bit tmo;
    clear_pairs();
    xs[0] = 65536; ws[0] = 65536;
    xs[1] = 32768; ws[1] = 32768;
    run_eval(0, 1'b0, 1'b0, z, s, lat, len, tmo);
    n_cmp++; if (tmo !== 1'b0)   begin n_fail++; $display("FAIL basic_timeout got %b want 0", tmo); end
    n_cmp++; if (z !== 20'd81920) begin n_fail++; $display("FAIL basic_z got %h want %h", z, 20'd81920); end
    n_cmp++; if (s !== 1'b0)     begin n_fail++; $display("FAIL basic_sat got %b want 0", s); end
    n_cmp++; if (lat !== 2)      begin n_fail++; $display("FAIL basic_latency got %0d want 2", lat); end
    n_cmp++; if (len !== 10)     begin n_fail++; $display("FAIL basic_eval_len got %0d want 10", len); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ovalid_drop got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_idle got busy=%b want 0", busy); end
    tick;
    n_cmp++; if (z_pre !== 20'd81920) begin n_fail++; $display("FAIL basic_hold_idle got %h want %h", z_pre, 20'd81920); end
  endtask

  task automatic test_pos_sat;
    logic [19:0] z; logic s; int lat, len; bit tmo;
    clear_pairs();
    xs[0] = 458752; ws[0] = 458752;
    run_eval(0, 1'b0, 1'b0, z, s, lat, len, tmo);
    n_cmp++; if (z !== 20'h7FFFF) begin n_fail++; $display("FAIL possat_z got %h want 7ffff", z); end
    n_cmp++; if (s !== 1'b1)      begin n_fail++; $display("FAIL possat_sat got %b want 1", s); end
    consume();
  endtask

  task automatic test_negative;
    logic [19:0] z; logic s; int lat, len; bit tmo;
    clear_pairs();
    xs[0] = -65536; ws[0] = 65536;
    run_eval(16384, 1'b0, 1'b0, z, s, lat, len, tmo);
    n_cmp++; if (z !== 20'hF4000) begin n_fail++; $display("FAIL neg_bias_z got %h want f4000", z); end
    n_cmp++; if (s !== 1'b0)      begin n_fail++; $display("FAIL neg_bias_sat got %b want 0", s); end
    consume();
    xs[0] = -458752; ws[0] = 458752;
    run_eval(16384, 1'b0, 1'b0, z, s, lat, len, tmo);
    n_cmp++; if (z !== 20'h80000) begin n_fail++; $display("FAIL negsat_z got %h want 80000", z); end
    n_cmp++; if (s !== 1'b1)      begin n_fail++; $display("FAIL negsat_sat got %b want 1", s); end
    consume();
  endtask

  task automatic test_rounding;
    logic [19:0] z; logic s; int lat, len; bit tmo;
    int          rx[4]   = '{1, 1, -1, -1};
    int          rw[4]   = '{32768, 32767, 32768, 32769};
    logic [19:0] rexp[4] = '{20'h00001, 20'h00000, 20'h00000, 20'hFFFFF};
    for (int k = 0; k < 4; k++) begin
      clear_pairs();
      xs[0] = rx[k]; ws[0] = rw[k];
      run_eval(0, 1'b0, 1'b0, z, s, lat, len, tmo);
      n_cmp++; if (z !== rexp[k]) begin n_fail++; $display("FAIL round_%0d got %h want %h", k, z, rexp[k]); end
      consume();
    end
  endtask

  task automatic test_random;
    logic [19:0] z, ez; logic s, es; int lat, len, b; bit tmo;
    for (int k = 0; k < 6; k++) begin
      random_pairs();
      b = rnd_fx(262144);
      model(b, ez, es);
      run_eval(b, 1'b1, 1'b0, z, s, lat, len, tmo);
      n_cmp++; if (z !== ez || s !== es) begin n_fail++; $display("FAIL random_%0d got z=%h sat=%b want z=%h sat=%b", k, z, s, ez, es); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL random_lat_%0d got %0d want 2", k, lat); end
      consume();
    end
  endtask

  task automatic test_handshake_stress;
    logic [19:0] z, ez; logic s, es; int lat, len, b; bit tmo;
    random_pairs();
    b = rnd_fx(262144);
    model(b, ez, es);
    run_eval(b, 1'b1, 1'b1, z, s, lat, len, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL stress_timeout got %b want 0", tmo); end
    n_cmp++; if (z !== ez || s !== es) begin n_fail++; $display("FAIL stress_result got z=%h sat=%b want z=%h sat=%b", z, s, ez, es); end
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(0, 1));
      tick;
      n_cmp++; if (out_valid !== 1'b1 || z_pre !== ez || sat !== es) begin
        n_fail++; $display("FAIL stress_hold_%0d got ov=%b z=%h sat=%b want ov=1 z=%h sat=%b", k, out_valid, z_pre, sat, ez, es);
      end
    end
    consume();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stress_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] z, ez; logic s, es; int lat, len, b; bit tmo;
    for (int k = 0; k < 2; k++) begin
      random_pairs();
      b = rnd_fx(65536);
      model(b, ez, es);
      run_eval(b, 1'b0, 1'b0, z, s, lat, len, tmo);
      n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL b2b_len_%0d got %0d want 10", k, len); end
      n_cmp++; if (z !== ez || s !== es) begin n_fail++; $display("FAIL b2b_result_%0d got z=%h sat=%b want z=%h sat=%b", k, z, s, ez, es); end
      consume();
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] z, ez; logic s, es; int lat, len, b; bit tmo;
    random_pairs();
    start = 1'b1;
    bias  = 20'(rnd_fx(65536));
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in     = 20'(xs[i]);
      w_in     = 20'(ws[i]);
      tick;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || z_pre !== 20'h0 || sat !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got ir=%b ov=%b busy=%b z=%h sat=%b want all 0", in_ready, out_valid, busy, z_pre, sat);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    random_pairs();
    b = rnd_fx(262144);
    model(b, ez, es);
    run_eval(b, 1'b1, 1'b0, z, s, lat, len, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout got %b want 0", tmo); end
    n_cmp++; if (z !== ez || s !== es) begin n_fail++; $display("FAIL midrst_fresh got z=%h sat=%b want z=%h sat=%b", z, s, ez, es); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_pos_sat();
    test_negative();
    test_rounding();
    test_random();
    test_handshake_stress();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
